mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage between the memory-access unit and write-back. It captures one memory-stage result per accepted transfer and converts misaligned accesses into a precise exception record. It replaces stall-based holding with a valid/ready handshake and a compile-time optional two-entry skid buffer. It also keeps a saturating count of misalignment exceptions for debug.

## Interface
Parameters:
- DATA_W, 32, width of memory result / write-back data
- PC_W, 30, word-address PC width
- REG_AW, 5, GPR address width
- CTRL_W, 2, control-op width; value 0 = CTRL_OP_NOP
- EXP_W, 3, exception-code width; value 0 = no exception
- MISS_ALIGN_CODE, 3'h2, exception code written for misaligned access
- CNT_W, 16, misalignment counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_pc / in_en / in_br_flag  in  PC_W / 1 / 1  passed through
- in_ctrl_op  in  CTRL_W  control op
- in_dst_addr  in  REG_AW  destination GPR
- in_gpr_we_  in  1  GPR write enable, active-low
- in_exp_code  in  EXP_W  upstream exception code
- in_out  in  DATA_W  memory-access result
- in_miss_align  in  1  access was misaligned
- out_valid  out  1  entry presented to write-back
- out_ready  in  1  write-back consumes entry
- out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_out  out  matching widths  held entry fields
- miss_align_cnt  out  CNT_W  saturating misalignment count

## Operation
- Accept = in_valid & in_ready & !flush. Consume = out_valid & out_ready.
- Accepted entry with in_miss_align=0: all fields copied unchanged.
- Accepted entry with in_miss_align=1: pc, en and br_flag copied. ctrl_op=0, dst_addr=0, gpr_we_=1, exp_code=MISS_ALIGN_CODE, out=0. This applies regardless of in_exp_code.
- "Cleared entry" means valid=0, pc=0, en=0, br_flag=0, ctrl_op=0, dst_addr=0, gpr_we_=1, exp_code=0, out=0.
- Flush: every entry becomes cleared next cycle. A simultaneous in_valid is dropped. A simultaneous consume is still counted as consumed by downstream. Flush overrides out_ready and in_valid.
- miss_align_cnt increments by 1 on each accept with in_miss_align=1. It saturates at 2^CNT_W−1. It is cleared only by reset; flush does not affect it.
- State (skid build): entries MAIN (drives out_*) and SKID. Occupancy states:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with consume.
  - ONE → EMPTY on consume without accept.
  - ONE → FULL on accept without consume; the new entry goes to SKID.
  - FULL → ONE on consume: SKID moves to MAIN. No accept is possible in FULL.
  - Any state → EMPTY on flush.

## Timing
- Reset: all outputs 0 except out_gpr_we_=1. in_ready=1 in the skid build. miss_align_cnt=0.
- Latency: accept in cycle N → out_valid=1 with that entry in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- Skid build: in_ready = !SKID.valid, registered with no combinational path from out_ready. out_* stay stable while out_valid & !out_ready.
- Reset asserted mid-transfer wins over everything; the held entries are lost.

## Configuration
- MEM_WB_SKID_EN defined: two-entry skid buffer as above. in_ready is registered.
- Undefined: single entry (MAIN only). in_ready = !out_valid | out_ready, a combinational path. No FULL state. All other behaviour is identical, including flush, misalign conversion and the counter.

## Test plan
- Reset then idle: out_valid=0, out_gpr_we_=1, exp_code=0, miss_align_cnt=0. In the skid build, in_ready=1.
- Accept pc=0x100, dst=5, gpr_we_=0, out=0xDEADBEEF with out_ready=1 → out_valid next cycle with identical fields. Then 10 back-to-back entries → 1/cycle with no bubbles.
- Accept with in_miss_align=1, dst=7, ctrl_op=1, pc=0x20 → out_pc=0x20, dst=0, ctrl_op=0, gpr_we_=1, exp_code=2, out=0, and miss_align_cnt=1.
- Skid build: hold out_ready=0 and offer A, B, C. A is shown, B goes to SKID, in_ready drops, C is held upstream. Raise out_ready → A, B, C emerge in order with none lost or duplicated.
- FULL state plus flush together with in_valid=1 → next cycle out_valid=0, all fields at cleared values, in_ready=1, and the incoming entry is dropped.
- With CNT_W=2, do 5 misaligned accepts → miss_align_cnt=3. A flush leaves it at 3; reset returns it to 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with a valid/ready handshake.
//   Captures one memory-stage result per accepted transfer. Misaligned
//   accesses become a precise exception record: the PC is kept and the
//   register write is suppressed. A saturating counter tracks misaligned
//   accepts for debug.
//
// Optional feature: define MEM_WB_SKID_EN for a two-entry skid buffer
//   (MAIN + SKID) with a registered in_ready. Without it the stage holds a
//   single entry and in_ready = !out_valid | out_ready (combinational).
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   flush                clears all held entries and drops any incoming entry
//   in_valid/in_ready    upstream handshake
//   in_*                 memory-stage fields (pc, en, br_flag, ctrl_op,
//                        dst_addr, gpr_we_ (active-low), exp_code, out,
//                        miss_align)
//   out_valid/out_ready  downstream handshake
//   out_*                fields of the entry held in MAIN
//   miss_align_cnt       saturating count of misaligned accepts (reset only)
module mem_wb_stage #(
  parameter int unsigned      DATA_W          = 32,
  parameter int unsigned      PC_W            = 30,
  parameter int unsigned      REG_AW          = 5,
  parameter int unsigned      CTRL_W          = 2,
  parameter int unsigned      EXP_W           = 3,
  parameter logic [EXP_W-1:0] MISS_ALIGN_CODE = 3'h2,
  parameter int unsigned      CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_en,
  input  logic              in_br_flag,
  input  logic [CTRL_W-1:0] in_ctrl_op,
  input  logic [REG_AW-1:0] in_dst_addr,
  input  logic              in_gpr_we_,
  input  logic [EXP_W-1:0]  in_exp_code,
  input  logic [DATA_W-1:0] in_out,
  input  logic              in_miss_align,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_en,
  output logic              out_br_flag,
  output logic [CTRL_W-1:0] out_ctrl_op,
  output logic [REG_AW-1:0] out_dst_addr,
  output logic              out_gpr_we_,
  output logic [EXP_W-1:0]  out_exp_code,
  output logic [DATA_W-1:0] out_out,
  output logic [CNT_W-1:0]  miss_align_cnt
);

  localparam logic [CTRL_W-1:0] CTRL_OP_NOP = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              en;
    logic              br_flag;
    logic [CTRL_W-1:0] ctrl_op;
    logic [REG_AW-1:0] dst_addr;
    logic              gpr_we_;
    logic [EXP_W-1:0]  exp_code;
    logic [DATA_W-1:0] out;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Cleared entry: everything zero except the active-low write enable.
  function automatic entry_t cleared_entry();
    entry_t e;
    e         = '0;
    e.gpr_we_ = 1'b1;
    return e;
  endfunction

  entry_t in_entry_s;
  logic   in_ready_s;
  logic   accept_s;
  logic   consume_s;

  occ_e   occ_q;
  logic   out_valid_q;
  entry_t main_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef MEM_WB_SKID_EN
  entry_t skid_q;
  logic   in_ready_q;
  // Registered ready: no combinational path from out_ready to in_ready.
  assign in_ready_s = in_ready_q;
`else
  // Single entry: the slot frees in the same cycle downstream consumes it.
  assign in_ready_s = ~out_valid_q | out_ready;
`endif

  assign accept_s  = in_valid & in_ready_s & ~flush;
  assign consume_s = out_valid_q & out_ready;

  // Misaligned access turns into an exception record; PC/en/br_flag kept.
  always_comb begin
    in_entry_s.pc      = in_pc;
    in_entry_s.en      = in_en;
    in_entry_s.br_flag = in_br_flag;
    if (in_miss_align) begin
      in_entry_s.ctrl_op  = CTRL_OP_NOP;
      in_entry_s.dst_addr = '0;
      in_entry_s.gpr_we_  = 1'b1;
      in_entry_s.exp_code = MISS_ALIGN_CODE;
      in_entry_s.out      = '0;
    end else begin
      in_entry_s.ctrl_op  = in_ctrl_op;
      in_entry_s.dst_addr = in_dst_addr;
      in_entry_s.gpr_we_  = in_gpr_we_;
      in_entry_s.exp_code = in_exp_code;
      in_entry_s.out      = in_out;
    end
  end

  // Occupancy FSM with the MAIN/SKID entries and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= cleared_entry();
`ifdef MEM_WB_SKID_EN
      skid_q      <= cleared_entry();
      in_ready_q  <= 1'b1;
`endif
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept_s) begin
            occ_q       <= OCC_ONE;
            out_valid_q <= 1'b1;
            main_q      <= in_entry_s;
          end
        end
        OCC_ONE: begin
`ifdef MEM_WB_SKID_EN
          if (accept_s && consume_s) begin
            main_q <= in_entry_s;
          end else if (accept_s) begin
            // Downstream stalled: park the newcomer and close the input.
            skid_q     <= in_entry_s;
            occ_q      <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (consume_s) begin
            occ_q       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
`else
          // An accept while occupied implies out_ready, i.e. a consume.
          if (accept_s) begin
            main_q <= in_entry_s;
          end else if (consume_s) begin
            occ_q       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
`endif
        end
`ifdef MEM_WB_SKID_EN
        OCC_FULL: begin
          if (consume_s) begin
            main_q     <= skid_q;
            skid_q     <= cleared_entry();
            occ_q      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
`endif
        default: begin
          occ_q       <= OCC_EMPTY;
          out_valid_q <= 1'b0;
          main_q      <= cleared_entry();
        end
      endcase
    end
  end

  // Saturating misalignment count; flush deliberately leaves it alone.
  always_comb begin
    if (accept_s && in_miss_align && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_q;
  assign out_pc         = main_q.pc;
  assign out_en         = main_q.en;
  assign out_br_flag    = main_q.br_flag;
  assign out_ctrl_op    = main_q.ctrl_op;
  assign out_dst_addr   = main_q.dst_addr;
  assign out_gpr_we_    = main_q.gpr_we_;
  assign out_exp_code   = main_q.exp_code;
  assign out_out        = main_q.out;
  assign miss_align_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (default widths) plus a second
// instance with CNT_W=2 for counter saturation. Works in both the default
// and the MEM_WB_SKID_EN build.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_en, in_br_flag, in_gpr_we_, in_miss_align, out_ready;
  logic [29:0] in_pc;
  logic [1:0]  in_ctrl_op;
  logic [4:0]  in_dst_addr;
  logic [2:0]  in_exp_code;
  logic [31:0] in_out;

  logic        in_ready, out_valid, out_en, out_br_flag, out_gpr_we_;
  logic [29:0] out_pc;
  logic [1:0]  out_ctrl_op;
  logic [4:0]  out_dst_addr;
  logic [2:0]  out_exp_code;
  logic [31:0] out_out;
  logic [15:0] cnt;

  logic        d2_in_ready, d2_out_valid, d2_out_en, d2_out_br_flag, d2_out_gpr_we_;
  logic [29:0] d2_out_pc;
  logic [1:0]  d2_out_ctrl_op;
  logic [4:0]  d2_out_dst_addr;
  logic [2:0]  d2_out_exp_code;
  logic [31:0] d2_out_out;
  logic [1:0]  d2_cnt;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag), .in_ctrl_op(in_ctrl_op),
    .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .in_exp_code(in_exp_code),
    .in_out(in_out), .in_miss_align(in_miss_align), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
    .out_ctrl_op(out_ctrl_op), .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
    .out_exp_code(out_exp_code), .out_out(out_out), .miss_align_cnt(cnt)
  );

  mem_wb_stage #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag), .in_ctrl_op(in_ctrl_op),
    .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .in_exp_code(in_exp_code),
    .in_out(in_out), .in_miss_align(in_miss_align), .out_valid(d2_out_valid),
    .out_ready(out_ready), .out_pc(d2_out_pc), .out_en(d2_out_en),
    .out_br_flag(d2_out_br_flag), .out_ctrl_op(d2_out_ctrl_op),
    .out_dst_addr(d2_out_dst_addr), .out_gpr_we_(d2_out_gpr_we_),
    .out_exp_code(d2_out_exp_code), .out_out(d2_out_out), .miss_align_cnt(d2_cnt)
  );

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  ec;
    logic [31:0] out;
  } ent_t;

  typedef struct {
    ent_t in;
    logic miss;
    ent_t req;
  } vec_t;

  vec_t tab[6];
  ent_t sb_q[$];
  ent_t clr;
  int   cnt16, cnt2;
  bit   cleared_f;
  int   checks = 0;
  int   errors = 0;
  logic dummy;

  function automatic ent_t mk(input logic [29:0] pc, input logic en, input logic br,
                              input logic [1:0] ctrl, input logic [4:0] dst, input logic we_,
                              input logic [2:0] ec, input logic [31:0] o);
    ent_t e;
    e.pc = pc; e.en = en; e.br = br; e.ctrl = ctrl;
    e.dst = dst; e.we_ = we_; e.ec = ec; e.out = o;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_ent(input string nm, input ent_t e);
    chk({nm, ".pc"},   32'(out_pc),       32'(e.pc));
    chk({nm, ".en"},   32'(out_en),       32'(e.en));
    chk({nm, ".br"},   32'(out_br_flag),  32'(e.br));
    chk({nm, ".ctrl"}, 32'(out_ctrl_op),  32'(e.ctrl));
    chk({nm, ".dst"},  32'(out_dst_addr), 32'(e.dst));
    chk({nm, ".we_"},  32'(out_gpr_we_),  32'(e.we_));
    chk({nm, ".exp"},  32'(out_exp_code), 32'(e.ec));
    chk({nm, ".out"},  out_out,           e.out);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    cnt16 = 0; cnt2 = 0; cleared_f = 1'b1;
  endtask

  // One cycle: drive, check DUT state at negedge against the scoreboard, advance model.
  task automatic step(input logic v, input int idx, input logic ordy, input logic fl,
                      output logic acc);
    logic rdy, cons;
    in_valid = v; out_ready = ordy; flush = fl;
    in_pc = tab[idx].in.pc; in_en = tab[idx].in.en; in_br_flag = tab[idx].in.br;
    in_ctrl_op = tab[idx].in.ctrl; in_dst_addr = tab[idx].in.dst;
    in_gpr_we_ = tab[idx].in.we_; in_exp_code = tab[idx].in.ec;
    in_out = tab[idx].in.out; in_miss_align = tab[idx].miss;
    @(negedge clk);
`ifdef MEM_WB_SKID_EN
    rdy = (sb_q.size() < 2);
`else
    rdy = (sb_q.size() == 0) || ordy;
`endif
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) chk_ent("head", sb_q[0]);
    else if (cleared_f) chk_ent("cleared", clr);
    chk("cnt16", 32'(cnt), 32'(cnt16));
    chk("cnt2", 32'(d2_cnt), 32'(cnt2));
    acc  = v && rdy && !fl;
    cons = (sb_q.size() != 0) && ordy;
    if (fl) begin
      sb_q.delete();
      cleared_f = 1'b1;
    end else begin
      if (cons) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back(tab[idx].req);
        cleared_f = 1'b0;
      end
    end
    if (acc && tab[idx].miss) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int items[3];
    int nxt, cur, cyc;
    logic acc, v, ordy, fl;

    clr = mk(30'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0);
    tab[0] = '{mk(30'h100, 1'b1, 1'b0, 2'd0, 5'd5, 1'b0, 3'd0, 32'hDEADBEEF), 1'b0,
               mk(30'h100, 1'b1, 1'b0, 2'd0, 5'd5, 1'b0, 3'd0, 32'hDEADBEEF)};
    tab[1] = '{mk(30'h20, 1'b1, 1'b1, 2'd1, 5'd7, 1'b0, 3'd0, 32'h12345678), 1'b1,
               mk(30'h20, 1'b1, 1'b1, 2'd0, 5'd0, 1'b1, 3'd2, 32'h0)};
    tab[2] = '{mk(30'h3FFFFFFF, 1'b0, 1'b1, 2'd3, 5'd31, 1'b1, 3'd5, 32'hFFFFFFFF), 1'b0,
               mk(30'h3FFFFFFF, 1'b0, 1'b1, 2'd3, 5'd31, 1'b1, 3'd5, 32'hFFFFFFFF)};
    tab[3] = '{mk(30'h44, 1'b1, 1'b0, 2'd2, 5'd12, 1'b0, 3'd7, 32'hA5A5A5A5), 1'b1,
               mk(30'h44, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd2, 32'h0)};
    tab[4] = '{mk(30'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd3, 32'h0), 1'b0,
               mk(30'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd3, 32'h0)};
    tab[5] = '{mk(30'h1234, 1'b1, 1'b1, 2'd1, 5'd1, 1'b0, 3'd1, 32'h00000001), 1'b0,
               mk(30'h1234, 1'b1, 1'b1, 2'd1, 5'd1, 1'b0, 3'd1, 32'h00000001)};

    in_valid = 1'b0; in_pc = '0; in_en = 1'b0; in_br_flag = 1'b0; in_ctrl_op = '0;
    in_dst_addr = '0; in_gpr_we_ = 1'b1; in_exp_code = '0; in_out = '0;
    in_miss_align = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    do_reset();

    // Reset state while idle.
    step(1'b0, 0, 1'b0, 1'b0, dummy);
    step(1'b0, 0, 1'b0, 1'b0, dummy);

    // Table vectors, each accepted with downstream ready.
    for (int i = 0; i < 6; i++) step(1'b1, i, 1'b1, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);

    // Ten back-to-back entries: out_valid must stay high throughout.
    for (int i = 0; i < 10; i++) step(1'b1, i % 6, 1'b1, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);

    // A, B, C offered against a stalled consumer, then released.
    items[0] = 0; items[1] = 2; items[2] = 5;
    nxt = 0; cyc = 0;
    while ((nxt < 3 || sb_q.size() != 0) && cyc < 40) begin
      step(nxt < 3, (nxt < 3) ? items[nxt] : 0, cyc >= 5, 1'b0, acc);
      if (acc) nxt++;
      cyc++;
    end
    if (cyc >= 40) begin
      errors++;
      $display("FAIL abc_timeout actual=%0d sent expected=3", nxt);
    end

    // Stall to capacity, then flush with a new entry offered.
    step(1'b1, 0, 1'b0, 1'b0, dummy);
    step(1'b1, 2, 1'b0, 1'b0, dummy);
    step(1'b1, 5, 1'b0, 1'b1, dummy);
    chk("post_flush_valid", 32'(out_valid), 32'd0);
    chk("post_flush_rdy", 32'(in_ready), 32'd1);
    step(1'b0, 0, 1'b0, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);

    // Flush coinciding with a consume and an offered entry.
    step(1'b1, 3, 1'b1, 1'b0, dummy);
    step(1'b1, 1, 1'b1, 1'b1, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);

    // Random traffic with occasional flushes; upstream holds an item until taken.
    cur = 0; v = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!v) begin
        v   = ($urandom % 4) != 0;
        cur = $urandom % 6;
      end
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 25) == 0;
      step(v, cur, ordy, fl, acc);
      if (acc || fl) v = 1'b0;
    end

    // Counter: five misaligned accepts saturate the 2-bit copy at 3.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, (k % 2 == 1) ? 1 : 3, 1'b1, 1'b0, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);
    chk("cnt2_sat", 32'(d2_cnt), 32'd3);
    chk("cnt16_five", 32'(cnt), 32'd5);
    step(1'b1, 1, 1'b1, 1'b1, dummy);
    step(1'b0, 0, 1'b1, 1'b0, dummy);
    chk("cnt2_after_flush", 32'(d2_cnt), 32'd3);

    // Reset while entries are held: everything lost, counter cleared.
    step(1'b1, 0, 1'b0, 1'b0, dummy);
    step(1'b1, 2, 1'b0, 1'b0, dummy);
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, dummy);
    chk("cnt2_after_reset", 32'(d2_cnt), 32'd0);
    chk("valid_after_reset", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
